// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT output bus carrying a 16-bin frame and the peak-detect results
interface fft_peak_detect_if;
  logic fft_valid;
  logic [15:0][31:0] fft_d;
  logic done;
  logic [3:0] freq;
  logic [31:0] max_mag;
  logic busy;
  logic overrun;
  modport master (output fft_valid, fft_d, input done, freq, max_mag, busy, overrun);
  modport slave (input fft_valid, fft_d, output done, freq, max_mag, busy, overrun);
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: double-buffered 16-bin power scan reporting the strongest bin
module fft_peak_detect #(
  parameter bit SKIP_DC = 1'b0
) (
  input logic clk,
  input logic rst,
  fft_peak_detect_if.slave bus
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [15:0][31:0] cap, work;
  logic pending;
  logic [3:0] idx, best_idx, nxt_idx;
  logic [31:0] best_mag, nxt_mag, mag;
  logic signed [15:0] re, im;
  logic signed [31:0] re_sq, im_sq;
  logic cand;
  // power of the bin under scan and the running-best candidate after it
  always_comb begin
    re = work[idx][31:16];
    im = work[idx][15:0];
    re_sq = re * re;
    im_sq = im * im;
    mag = $unsigned(re_sq) + $unsigned(im_sq);
    cand = (mag > best_mag) && !(SKIP_DC && idx == 4'd0);
    nxt_mag = cand ? mag : best_mag;
    nxt_idx = cand ? idx : best_idx;
  end
  // capture bank always takes the newest frame
  always_ff @(posedge clk)
    if (bus.fft_valid) cap <= bus.fft_d;
  // work bank snapshots the capture bank as a scan starts
  always_ff @(posedge clk)
    if (state == IDLE && pending) work <= cap;
  // scan FSM, pending/overrun tracking and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= 1'b0;
      idx <= 4'd0;
      best_idx <= 4'd0;
      best_mag <= 32'd0;
      bus.done <= 1'b0;
      bus.freq <= 4'd0;
      bus.max_mag <= 32'd0;
      bus.busy <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.overrun <= bus.fft_valid && pending && state == CALC;
      pending <= bus.fft_valid || (pending && state == CALC);
      if (state == IDLE) begin
        if (pending) begin
          state <= CALC;
          idx <= 4'd0;
          best_mag <= 32'd0;
          best_idx <= SKIP_DC ? 4'd1 : 4'd0;
          bus.busy <= 1'b1;
        end
      end else begin
        best_mag <= nxt_mag;
        best_idx <= nxt_idx;
        idx <= idx + 4'd1;
        if (idx == 4'd15) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.freq <= nxt_idx;
          bus.max_mag <= nxt_mag;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: directed self-checking bench for fft_peak_detect
module tb_fft_peak_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic sel = 1'b0;
  logic [15:0][31:0] d = '0;
  logic [15:0][31:0] fr;
  int total = 0;
  int bad = 0;
  int got[$];
  int ov_cnt;
  int ov_first;
  always #5 clk = ~clk;
  fft_peak_detect_if bus0();
  fft_peak_detect_if bus1();
  assign bus0.fft_valid = valid;
  assign bus0.fft_d = d;
  assign bus1.fft_valid = valid;
  assign bus1.fft_d = d;
  fft_peak_detect #(.SKIP_DC(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fft_peak_detect #(.SKIP_DC(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  logic o_done, o_busy, o_overrun;
  logic [3:0] o_freq;
  logic [31:0] o_mag;
  assign o_done = sel ? bus1.done : bus0.done;
  assign o_busy = sel ? bus1.busy : bus0.busy;
  assign o_overrun = sel ? bus1.overrun : bus0.overrun;
  assign o_freq = sel ? bus1.freq : bus0.freq;
  assign o_mag = sel ? bus1.max_mag : bus0.max_mag;

  function automatic logic [15:0][31:0] make_peak(input int p);
    logic [15:0][31:0] f;
    for (int i = 0; i < 16; i++) f[i] = {16'd1, 16'd0};
    f[p] = {16'd200, 16'd0};
    return f;
  endfunction

  task automatic run_frame(output int lat, output int nbusy, output int ndone,
                           output logic [3:0] f, output logic [31:0] m);
    lat = -1; nbusy = 0; ndone = 0; f = 4'd0; m = 32'd0;
    @(negedge clk);
    valid = 1'b1;
    d = fr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      if (o_done) begin
        ndone++;
        if (lat < 0) begin lat = k - 1; f = o_freq; m = o_mag; end
      end
      nbusy += int'(o_busy);
    end
  endtask

  task automatic stream(input logic [15:0][31:0] fa, input logic [15:0][31:0] fb,
                        input logic [15:0][31:0] fc, input int t1, input int t2,
                        input int t3, input int ncyc);
    got.delete();
    ov_cnt = 0;
    ov_first = -1;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (o_done) got.push_back(int'(o_freq));
      if (o_overrun) begin
        ov_cnt++;
        if (ov_first < 0) ov_first = t;
      end
      valid = (t == t1 || t == t2 || t == t3);
      d = (t == t1) ? fa : (t == t2) ? fb : (t == t3) ? fc : d;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d got=%b exp=0", s, o_done); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", s, o_busy); end
      total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun dut%0d got=%b exp=0", s, o_overrun); end
      total++; if (o_freq !== 4'd0) begin bad++; $display("FAIL reset_freq dut%0d got=%0d exp=0", s, o_freq); end
      total++; if (o_mag !== 32'd0) begin bad++; $display("FAIL reset_mag dut%0d got=%0d exp=0", s, o_mag); end
    end
    sel = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int lat, nb, nd;
    logic [3:0] f;
    logic [31:0] m;
    sel = 1'b0;
    fr = '0;
    fr[5] = {16'd100, 16'd0};
    run_frame(lat, nb, nd, f, m);
    total++; if (lat !== 17) begin bad++; $display("FAIL single_latency got=%0d exp=17", lat); end
    total++; if (f !== 4'd5) begin bad++; $display("FAIL single_freq got=%0d exp=5", f); end
    total++; if (m !== 32'd10000) begin bad++; $display("FAIL single_mag got=%0d exp=10000", m); end
    total++; if (nb !== 16) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=16", nb); end
    total++; if (nd !== 1) begin bad++; $display("FAIL single_done_pulses got=%0d exp=1", nd); end
    fr = '0;
    run_frame(lat, nb, nd, f, m);
    total++; if (f !== 4'd0 || m !== 32'd0) begin bad++; $display("FAIL zero_frame got=%0d/%0d exp=0/0", f, m); end
  endtask

  task automatic test_tie_sign;
    int lat, nb, nd;
    logic [3:0] f;
    logic [31:0] m;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) fr[i] = {16'd1, 16'd1};
    fr[3] = {16'hFFFD, 16'h0004};
    fr[9] = {16'hFFFD, 16'h0004};
    run_frame(lat, nb, nd, f, m);
    total++; if (f !== 4'd3) begin bad++; $display("FAIL tie_freq got=%0d exp=3", f); end
    total++; if (m !== 32'd25) begin bad++; $display("FAIL tie_mag got=%0d exp=25", m); end
    fr[12] = {16'h8000, 16'h8000};
    run_frame(lat, nb, nd, f, m);
    total++; if (f !== 4'd12) begin bad++; $display("FAIL extreme_freq got=%0d exp=12", f); end
    total++; if (m !== 32'h80000000) begin bad++; $display("FAIL extreme_mag got=%h exp=80000000", m); end
  endtask

  task automatic test_skip_dc;
    int lat, nb, nd;
    logic [3:0] f;
    logic [31:0] m;
    sel = 1'b1;
    fr = '0;
    fr[0] = {16'd1000, 16'd0};
    fr[6] = {16'd10, 16'd0};
    run_frame(lat, nb, nd, f, m);
    total++; if (f !== 4'd6) begin bad++; $display("FAIL skipdc_freq got=%0d exp=6", f); end
    total++; if (m !== 32'd100) begin bad++; $display("FAIL skipdc_mag got=%0d exp=100", m); end
    total++; if (lat !== 17) begin bad++; $display("FAIL skipdc_latency got=%0d exp=17", lat); end
    fr = '0;
    run_frame(lat, nb, nd, f, m);
    total++; if (f !== 4'd1) begin bad++; $display("FAIL skipdc_zero_freq got=%0d exp=1", f); end
    total++; if (m !== 32'd0) begin bad++; $display("FAIL skipdc_zero_mag got=%0d exp=0", m); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    stream(make_peak(2), make_peak(7), make_peak(11), 0, 17, 34, 60);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL stream_count got=%0d exp=3", got.size()); end
    else begin
      total++; if (got[0] !== 2 || got[1] !== 7 || got[2] !== 11) begin bad++; $display("FAIL stream_order got=%0d,%0d,%0d exp=2,7,11", got[0], got[1], got[2]); end
    end
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL stream_overrun got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_overrun;
    sel = 1'b0;
    stream(make_peak(4), make_peak(8), make_peak(13), 0, 3, 6, 45);
    total++; if (ov_cnt !== 1) begin bad++; $display("FAIL overrun_count got=%0d exp=1", ov_cnt); end
    total++; if (ov_first !== 7) begin bad++; $display("FAIL overrun_cycle got=%0d exp=7", ov_first); end
    total++; if (got.size() !== 2) begin bad++; $display("FAIL overrun_done_count got=%0d exp=2", got.size()); end
    else begin
      total++; if (got[0] !== 4 || got[1] !== 13) begin bad++; $display("FAIL overrun_order got=%0d,%0d exp=4,13", got[0], got[1]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, nb, nd;
    logic [3:0] f;
    logic [31:0] m;
    sel = 1'b0;
    fr = make_peak(3);
    @(negedge clk);
    valid = 1'b1;
    d = fr;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
    end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL midscan_busy got=%b exp=1", o_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({o_done, o_busy, o_overrun} !== 3'b000) begin bad++; $display("FAIL midreset_flags got=%b exp=000", {o_done, o_busy, o_overrun}); end
    total++; if (o_freq !== 4'd0 || o_mag !== 32'd0) begin bad++; $display("FAIL midreset_result got=%0d/%0d exp=0/0", o_freq, o_mag); end
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      nd += int'(o_done) + int'(o_busy);
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL midreset_activity got=%0d exp=0", nd); end
    fr = make_peak(10);
    run_frame(lat, nb, nd, f, m);
    total++; if (lat !== 17) begin bad++; $display("FAIL after_reset_latency got=%0d exp=17", lat); end
    total++; if (f !== 4'd10) begin bad++; $display("FAIL after_reset_freq got=%0d exp=10", f); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie_sign;
    test_skip_dc;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
